arb4_rr: RTL and testbench

//  Round-robin arbiter sharing one resource among 4 requesters (4-to-2 encoded grant).

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick4.sv | 32 +++
 rtl/arb4_rr.sv | 125 ++++++++++++
 tb/tb_arb4_rr.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick: first set request at or after ptr, wrapping 3->0.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDX_W-1:0]  rot_idx;

  // Doubling the vector turns the rotate into a plain right shift.
  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> ptr);

  always_comb begin
    // NOTE: default first so every path assigns rot_idx; otherwise a latch is inferred.
    rot_idx = '0;
    if (req_rot[0])      rot_idx = 2'd0;
    else if (req_rot[1]) rot_idx = 2'd1;
    else if (req_rot[2]) rot_idx = 2'd2;
    else if (req_rot[3]) rot_idx = 2'd3;
  end

  // Undo the rotation; the 2-bit sum wraps mod 4 by itself.
  assign idx = rot_idx + ptr;
  assign any = |req;

endmodule

// File: rtl/arb4_rr.sv
// Round-robin arbiter, 4 level requesters, registered one-hot grant plus index/valid.
// Optional owner timeout with preemption is enabled by defining ARB_TIMEOUT_EN.
module arb4_rr
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (1 << HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("arb4_rr: MAX_HOLD must be 1..255 and fit in HOLD_W bits");
  end

  arb_state_e       state, state_next;
  logic [NREQ-1:0]  gnt_next;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_hit;
  logic             timeout_hit;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign release_hit = ~req[gnt_idx];
  assign gnt_vld     = |gnt;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              preempt_q, preempt_next;

  // Timeout only bites when someone else is actually waiting.
  assign timeout_hit = (hold_cnt == HOLD_LAST) && |(req & ~gnt);
  assign preempt     = preempt_q;
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    idx_next   = gnt_idx;
    ptr_next   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_next    = hold_cnt;
    preempt_next = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_BUSY;
          gnt_next   = NREQ'(1) << pick_idx;
          idx_next   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_next  = '0;
`endif
        end else begin
          gnt_next = '0;
          idx_next = '0;
        end
      end
      ARB_BUSY: begin
        // Release and timeout both go through IDLE, so every handover has a dead cycle.
        if (release_hit || timeout_hit) begin
          state_next = ARB_IDLE;
          gnt_next   = '0;
          idx_next   = '0;
          ptr_next   = gnt_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          preempt_next = timeout_hit & ~release_hit;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_cnt != '1) hold_next = hold_cnt + HOLD_W'(1);
`endif
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      gnt_idx <= idx_next;
      ptr     <= ptr_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_next;
      preempt_q <= preempt_next;
    end
  end
`endif

endmodule

// File: tb/tb_arb4_rr.sv
// Self-checking bench for arb4_rr: per-cycle expected outputs go through a scoreboard queue.
module tb_arb4_rr;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       pre;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int   total = 0;
  int   bad   = 0;
  out_t exp_q[$];

  arb4_rr #(.MAX_HOLD(8), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  function automatic out_t exp_of(input logic [3:0] g, input logic p);
    out_t o;
    o.gnt = g;
    o.vld = |g;
    o.pre = p;
    case (g)
      4'b0010: o.idx = 2'd1;
      4'b0100: o.idx = 2'd2;
      4'b1000: o.idx = 2'd3;
      default: o.idx = 2'd0;
    endcase
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("gnt=%b idx=%0d vld=%b pre=%b", o.gnt, o.idx, o.vld, o.pre);
  endfunction

  function automatic out_t observed();
    out_t o;
    o.gnt = gnt;
    o.idx = gnt_idx;
    o.vld = gnt_vld;
    o.pre = preempt;
    return o;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_t e, o;
    req = 4'b1111;
    exp_q.push_back(exp_of(4'b0000, 1'b0));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = observed();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL reset_hold: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [3:0] rq [3] = '{4'b0010, 4'b0000, 4'b0100};
    logic [3:0] eg [3] = '{4'b0010, 4'b0000, 4'b0100};
    out_t e, o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_of(eg[i], 1'b0));
      req = rq[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL mid_setup[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
    // Async reset between edges: outputs must drop without a clock.
    #2;
    exp_q.push_back(exp_of(4'b0000, 1'b0));
    rst = 1'b1;
    #1;
    e = exp_q.pop_front();
    o = observed();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL mid_async_drop: got %s want %s", fmt(o), fmt(e));
    end
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    // ptr was 2 before reset; a fresh all-request must go to requester 0.
    exp_q.push_back(exp_of(4'b0001, 1'b0));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = observed();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL mid_ptr_cleared: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_basic();
    logic [3:0] rq [6] = '{4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] eg [6] = '{4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    out_t e, o;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exp_of(eg[i], 1'b0));
      req = rq[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL basic[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rq [9] = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111,
                           4'b1011, 4'b1111, 4'b0111, 4'b1111};
    logic [3:0] eg [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                           4'b0000, 4'b1000, 4'b0000, 4'b0001};
    out_t e, o;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(exp_of(eg[i], 1'b0));
      req = rq[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rr[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [3] = '{4'b0100, 4'b0000, 4'b0011};
    logic [3:0] eg [3] = '{4'b0100, 4'b0000, 4'b0001};
    out_t e, o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_of(eg[i], 1'b0));
      req = rq[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL wrap[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] rq [5] = '{4'b0010, 4'b0111, 4'b1011, 4'b1101, 4'b1101};
    logic [3:0] eg [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
    out_t e, o;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exp_of(eg[i], 1'b0));
      req = rq[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL busy[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] rq [10];
    logic [3:0] eg [10];
    logic       ep [10];
    out_t e, o;
    rq[0] = 4'b0100; eg[0] = 4'b0100; ep[0] = 1'b0;
    for (int i = 1; i < 8; i++) begin
      rq[i] = 4'b0101; eg[i] = 4'b0100; ep[i] = 1'b0;
    end
`ifdef ARB_TIMEOUT_EN
    rq[8] = 4'b0101; eg[8] = 4'b0000; ep[8] = 1'b1;
    rq[9] = 4'b0001; eg[9] = 4'b0001; ep[9] = 1'b0;
`else
    rq[8] = 4'b0101; eg[8] = 4'b0100; ep[8] = 1'b0;
    rq[9] = 4'b0001; eg[9] = 4'b0000; ep[9] = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(exp_of(eg[i], ep[i]));
      req = rq[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL timeout[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_sole_owner();
    out_t e, o;
    do_reset();
    for (int i = 0; i < 301; i++) begin
      exp_q.push_back(exp_of(4'b0010, 1'b0));
      req = 4'b0010;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL sole[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_grant();
    test_basic();
    test_round_robin();
    test_wrap();
    test_busy_ignore();
    test_timeout();
    test_sole_owner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
